// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - multicycle RV32I main control FSM with memory timeout, sticky fault and retire counter
module multicycle_main_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             Branch,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              retire;
    logic              is_wait;
    logic              timed_out;
    logic              ir_write, pc_update, reg_write, mem_write, branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            wait_q       <= '0;
            fault_code_q <= 2'b00;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            fault_code_q <= fault_code_d;
            retired_q    <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        retire       = 1'b0;
        is_wait      = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
        timed_out    = (TIMEOUT != 0) && is_wait && !mem_ready && (wait_q == WAIT_LIM);

        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d      = S_FAULT;
                        fault_code_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_ALUWB, S_BEQ: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JAL:      state_d = S_ALUWB;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FETCH;
        endcase

        // A ready response in the limit cycle has already left the wait state above.
        if (timed_out) begin
            state_d      = S_FAULT;
            fault_code_d = 2'b10;
        end

        wait_d = '0;
        if (is_wait && !mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        retired_d = retired_q;
        if (retire && (retired_q != '1)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        ir_write  = 1'b0;
        pc_update = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write  = mem_ready;
                pc_update = mem_ready;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Strobes are gated by rst_n so FETCH's mem_ready pass-through cannot fire during reset.
    assign IRWrite    = ir_write  & rst_n;
    assign PCUpdate   = pc_update & rst_n;
    assign RegWrite   = reg_write & rst_n;
    assign MemWrite   = mem_write & rst_n;
    assign Branch     = branch    & rst_n;
    assign fault      = (state_q == S_FAULT);
    assign fault_code = fault_code_q;
    assign retired    = retired_q;
endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Multicycle successor to the single-cycle main decoder. It sequences each RV32I instruction (lw, sw, R-type, I-type ALU, beq, jal) over several cycles, producing the same class of control outputs plus multicycle-specific datapath strobes. It adds a memory ready handshake with a parametrised timeout, a sticky fault state, and a saturating retired-instruction counter. It sits between the instruction register's opcode field and the multicycle datapath.

## Interface
- TIMEOUT, 16, consecutive not-ready cycles tolerated in a memory-wait state; 0 disables timeout
- CNT_W, 32, width of the retired-instruction counter
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- op  input  7  opcode from the instruction register, stable from DECODE until the next FETCH
- mem_ready  input  1  memory completes the current access this cycle
- IRWrite  output  1  load the instruction register
- PCUpdate  output  1  write PC (with Branch: PC written if Branch & Zero)
- AdrSrc  output  1  0 = PC, 1 = Result drives the memory address
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rd1
- ALUSrcB  output  2  00 rd2, 01 imm, 10 constant 4
- ALUOp  output  2  00 add, 01 subtract/compare, 10 funct-decoded
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ImmSrc  output  2  combinational from op: 0000011/0010011 → 00, 0100011 → 01, 1100011 → 10, 1101111 → 11, others → 00
- RegWrite, MemWrite, Branch  output  1 each  register-file write, memory write, branch qualifier
- fault  output  1  sticky error flag
- fault_code  output  2  00 none, 01 illegal opcode, 10 memory timeout
- retired  output  CNT_W  instructions completed, saturating

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, FAULT.
- Outputs are Moore except IRWrite and PCUpdate in FETCH, which equal mem_ready. Outputs not listed for a state are 0.
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, ALUOp 00. Transitions to DECODE on mem_ready; otherwise holds.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other op → FAULT with code 01
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. Goes to MEMREAD if op = 0000011, else MEMWRITE.
- MEMREAD: AdrSrc 1, ResultSrc 00. Transitions to MEMWB on mem_ready; otherwise holds.
- MEMWB: ResultSrc 01, RegWrite 1. Returns to FETCH.
- MEMWRITE: AdrSrc 1, ResultSrc 00. MemWrite is held at 1 until mem_ready, then returns to FETCH.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp 10. Goes to ALUWB.
- EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp 10. Goes to ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1. Returns to FETCH.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1. Returns to FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1. Goes to ALUWB.
- FAULT: all strobes 0, mux selects at FETCH values, fault 1. Exits only by reset.
- Timeout (memory-wait states FETCH, MEMREAD, MEMWRITE):
  - wait counter clears on entry to a wait state and on mem_ready.
  - It increments on each wait-state cycle with mem_ready 0.
  - If it equals TIMEOUT-1 and mem_ready is 0, next state is FAULT with code 10.
  - mem_ready in the limit cycle wins over the timeout.
- retired increments by 1 on each transition from MEMWB, ALUWB, BEQ, or MEMWRITE (with mem_ready) to FETCH. It holds at 2^CNT_W-1 once saturated. JAL retires via ALUWB.
- fault_code latches the first cause only.

## Timing
- Reset (rst_n low, asynchronous):
  - state FETCH, fault 0, fault_code 00, retired 0, wait counter 0.
  - IRWrite, PCUpdate, RegWrite, MemWrite and Branch are forced to 0 while rst_n is low.
  - Mux selects take FETCH values.
- After deassertion, the first rising edge evaluates FETCH normally.
- Zero-wait latency (cycles from FETCH to the next FETCH): beq 3; R-type, I-type, sw, jal 4; lw 5. Each memory-wait cycle adds 1.
- An illegal op reaches FAULT at the edge ending DECODE, so fault is high 2 cycles after FETCH completes.
- Reset mid-instruction aborts immediately. No write strobe stays asserted after rst_n falls.

## Test plan
- R-type, mem_ready tied 1:
  - states FETCH, DECODE, EXECR, ALUWB, FETCH.
  - RegWrite is 1 only in cycle 4; retired goes 0 → 1.
- lw with mem_ready low for 3 cycles in MEMREAD:
  - 8 cycles total.
  - ResultSrc 01 and RegWrite 1 in MEMWB.
  - AdrSrc 1 throughout MEMREAD.
- sw with TIMEOUT = 4 and mem_ready held 0:
  - MemWrite stays 1 for 4 cycles, then FAULT.
  - fault 1, fault_code 10, retired unchanged.
- op = 1111111:
  - DECODE → FAULT; fault_code 01.
  - A later mem_ready pulse does not clear it; only rst_n does.
- CNT_W = 3, nine beq instructions: retired saturates at 7.
- Assert rst_n low during MEMWRITE: MemWrite drops asynchronously, and after release the state is FETCH with all counters 0.
